// File: rtl/dcg_pkg.sv
// Shared types and constants for the dual code grant sequencer.
package dcg_pkg;

  localparam int N_REQ  = 12;
  localparam int CODE_W = 4;

  localparam logic [CODE_W-1:0] CODE_NONE = '0;
  localparam logic [CODE_W-1:0] CODE_MAX  = CODE_W'(N_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND1 = 2'd1,
    SEND2 = 2'd2
  } dcg_state_t;

  // A code names a real request line when it lies in 1..N_REQ.
  function automatic logic code_valid(input logic [CODE_W-1:0] code);
    return (code != CODE_NONE) && (code <= CODE_MAX);
  endfunction

  // A non-zero code beyond the last request line is a protocol error.
  function automatic logic code_oor(input logic [CODE_W-1:0] code);
    return code > CODE_MAX;
  endfunction

endpackage

// File: rtl/dual_code_grant_seq_code_to_onehot.sv
// Combinational decode of a request code to a one-hot grant vector.
// Invalid codes (zero or out of range) decode to all-zero.
module code_to_onehot
  import dcg_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [N_REQ-1:0]  onehot
);

  // Bit k-1 is set only for a valid code k.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      onehot[i] = code_valid(code) && (code == CODE_W'(i + 1));
    end
  end

endmodule

// File: rtl/dual_code_grant_seq.sv
// Dual code grant sequencer: accepts a (p1,p2) code pair and issues the
// corresponding one-hot grants one per output handshake, p1 first.
// Optional feature macro: DCG_MERGE_EN adds the all_grant output, the
// merged one-hot of both accepted codes.
//
// state | meaning
// IDLE  | ready for a new code pair, no grant presented
// SEND1 | presenting the grant for the first code (c1)
// SEND2 | presenting the grant for the second code (c2)
module dual_code_grant_seq
  import dcg_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] p1,
  input  logic [CODE_W-1:0] p2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_REQ-1:0]  grant,
  output logic [CODE_W-1:0] out_code,
  output logic              err
`ifdef DCG_MERGE_EN
  ,
  output logic [N_REQ-1:0]  all_grant
`endif
);

  dcg_state_t        state;
  logic [CODE_W-1:0] c1;
  logic [CODE_W-1:0] c2;
  logic [N_REQ-1:0]  oh_p1;
  logic [N_REQ-1:0]  oh_p2;
  logic [N_REQ-1:0]  oh_c2;
  logic              accept;

  code_to_onehot u_dec_p1 (.code(p1), .onehot(oh_p1));
  code_to_onehot u_dec_p2 (.code(p2), .onehot(oh_p2));
  code_to_onehot u_dec_c2 (.code(c2), .onehot(oh_c2));

  // Input side is open only while no grant is pending.
  always_comb begin
    in_ready = (state == IDLE);
    accept   = in_valid && in_ready;
  end

  // Sequencer: latches the pair on accept and walks the grants out.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      c1        <= CODE_NONE;
      c2        <= CODE_NONE;
      out_valid <= 1'b0;
      grant     <= '0;
      out_code  <= CODE_NONE;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            c1  <= p1;
            c2  <= p2;
            err <= code_oor(p1) || code_oor(p2);
            if (code_valid(p1)) begin
              state     <= SEND1;
              out_valid <= 1'b1;
              grant     <= oh_p1;
              out_code  <= p1;
            end else if (code_valid(p2)) begin
              state     <= SEND2;
              out_valid <= 1'b1;
              grant     <= oh_p2;
              out_code  <= p2;
            end
          end
        end
        SEND1: begin
          if (out_ready) begin
            // A second code equal to the first is a duplicate, not a new grant.
            if (code_valid(c2) && (c2 != c1)) begin
              state    <= SEND2;
              grant    <= oh_c2;
              out_code <= c2;
            end else begin
              state     <= IDLE;
              out_valid <= 1'b0;
              grant     <= '0;
              out_code  <= CODE_NONE;
            end
          end
        end
        SEND2: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            grant     <= '0;
            out_code  <= CODE_NONE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          grant     <= '0;
          out_code  <= CODE_NONE;
        end
      endcase
    end
  end

`ifdef DCG_MERGE_EN
  // Merged view of both accepted codes, held until the next accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      all_grant <= '0;
    end else if (accept) begin
      all_grant <= oh_p1 | oh_p2;
    end
  end
`endif

endmodule

// File: tb/tb_dual_code_grant_seq.sv
// Directed self-checking bench for dual_code_grant_seq.
module tb_dual_code_grant_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  p1 = '0;
  logic [3:0]  p2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] grant;
  logic [3:0]  out_code;
  logic        err;
`ifdef DCG_MERGE_EN
  logic [11:0] all_grant;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  dual_code_grant_seq dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .p1        (p1),
    .p2        (p2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .grant     (grant),
    .out_code  (out_code),
    .err       (err)
`ifdef DCG_MERGE_EN
    ,
    .all_grant (all_grant)
`endif
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a pair for exactly one edge (DUT is expected to be IDLE).
  task automatic send_pair(input logic [3:0] a, input logic [3:0] b);
    in_valid = 1'b1;
    p1 = a;
    p2 = b;
    step();
    in_valid = 1'b0;
    p1 = '0;
    p2 = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_checks++;
    if (out_valid !== 1'b0 || grant !== 12'h000 || out_code !== 4'd0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: out_valid=%b grant=%h out_code=%0d err=%b, want 0/000/0/0",
               out_valid, grant, out_code, err);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
`ifdef DCG_MERGE_EN
    n_checks++;
    if (all_grant !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_all_grant: got %h want 000", all_grant);
    end
`endif
    reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    out_ready = 1'b0;
    send_pair(4'd12, 4'd0);
    n_checks++;
    if (out_valid !== 1'b1 || grant !== 12'h800 || out_code !== 4'd12) begin
      n_fail++;
      $display("FAIL single_grant: out_valid=%b grant=%h code=%0d want 1/800/12", out_valid, grant, out_code);
    end
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL single_busy: in_ready=%b want 0", in_ready);
    end
    out_ready = 1'b1;
    step();
    n_checks++;
    if (out_valid !== 1'b0 || grant !== 12'h000 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_done: out_valid=%b grant=%h in_ready=%b want 0/000/1", out_valid, grant, in_ready);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_pair();
    out_ready = 1'b1;
    send_pair(4'd8, 4'd7);
    n_checks++;
    if (out_valid !== 1'b1 || grant !== 12'h080 || out_code !== 4'd8) begin
      n_fail++;
      $display("FAIL pair_first: out_valid=%b grant=%h code=%0d want 1/080/8", out_valid, grant, out_code);
    end
`ifdef DCG_MERGE_EN
    n_checks++;
    if (all_grant !== 12'h0C0) begin
      n_fail++;
      $display("FAIL pair_all_grant: got %h want 0c0", all_grant);
    end
`endif
    step();
    n_checks++;
    if (out_valid !== 1'b1 || grant !== 12'h040 || out_code !== 4'd7) begin
      n_fail++;
      $display("FAIL pair_second: out_valid=%b grant=%h code=%0d want 1/040/7", out_valid, grant, out_code);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b0 || grant !== 12'h000 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL pair_done: out_valid=%b grant=%h in_ready=%b want 0/000/1", out_valid, grant, in_ready);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int bad_hold = 0;
    out_ready = 1'b0;
    send_pair(4'd12, 4'd1);
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || grant !== 12'h800 || out_code !== 4'd12 || in_ready !== 1'b0)
        bad_hold++;
      step();
    end
    n_checks++;
    if (bad_hold != 0) begin
      n_fail++;
      $display("FAIL hold_stable: %0d unstable cycles, want 0 (grant=%h in_ready=%b)", bad_hold, grant, in_ready);
    end
    out_ready = 1'b1;
    step();
    n_checks++;
    if (out_valid !== 1'b1 || grant !== 12'h001 || out_code !== 4'd1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_second: out_valid=%b grant=%h code=%0d in_ready=%b want 1/001/1/0",
               out_valid, grant, out_code, in_ready);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_done: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_none_and_err();
    out_ready = 1'b0;
    send_pair(4'd0, 4'd0);
    n_checks++;
    if (out_valid !== 1'b0 || err !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL none_pair: out_valid=%b err=%b in_ready=%b want 0/0/1", out_valid, err, in_ready);
    end
    send_pair(4'd14, 4'd3);
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_pulse: got %b want 1", err);
    end
    n_checks++;
    if (out_valid !== 1'b1 || grant !== 12'h004 || out_code !== 4'd3) begin
      n_fail++;
      $display("FAIL err_grant: out_valid=%b grant=%h code=%0d want 1/004/3", out_valid, grant, out_code);
    end
`ifdef DCG_MERGE_EN
    n_checks++;
    if (all_grant !== 12'h004) begin
      n_fail++;
      $display("FAIL err_all_grant: got %h want 004", all_grant);
    end
`endif
    step();
    n_checks++;
    if (err !== 1'b0 || out_valid !== 1'b1 || grant !== 12'h004) begin
      n_fail++;
      $display("FAIL err_one_cycle: err=%b out_valid=%b grant=%h want 0/1/004", err, out_valid, grant);
    end
    out_ready = 1'b1;
    step();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL err_done: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_duplicate();
    out_ready = 1'b0;
    send_pair(4'd5, 4'd5);
    n_checks++;
    if (out_valid !== 1'b1 || grant !== 12'h010 || out_code !== 4'd5 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL dup_grant: out_valid=%b grant=%h code=%0d err=%b want 1/010/5/0",
               out_valid, grant, out_code, err);
    end
    out_ready = 1'b1;
    step();
    n_checks++;
    if (out_valid !== 1'b0 || grant !== 12'h000 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL dup_single: out_valid=%b grant=%h in_ready=%b want 0/000/1", out_valid, grant, in_ready);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int leaked = 0;
    out_ready = 1'b0;
    send_pair(4'd3, 4'd9);
    n_checks++;
    if (out_valid !== 1'b1 || grant !== 12'h004) begin
      n_fail++;
      $display("FAIL mid_pre: out_valid=%b grant=%h want 1/004", out_valid, grant);
    end
    reset = 1'b1;
    out_ready = 1'b1;
    step();
    n_checks++;
    if (out_valid !== 1'b0 || grant !== 12'h000 || out_code !== 4'd0) begin
      n_fail++;
      $display("FAIL mid_reset: out_valid=%b grant=%h code=%0d want 0/000/0", out_valid, grant, out_code);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (out_valid !== 1'b0 || grant !== 12'h000) leaked++;
    end
    n_checks++;
    if (leaked != 0) begin
      n_fail++;
      $display("FAIL mid_no_p2: %0d cycles with a grant after reset, want 0 (grant=%h)", leaked, grant);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int accepts = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    p1 = 4'd1;
    p2 = 4'd0;
    // Single-grant pairs with input held valid: one accept every 2 cycles.
    for (int i = 0; i < 6; i++) begin
      if (in_ready === 1'b1) accepts++;
      step();
    end
    in_valid = 1'b0;
    p1 = '0;
    n_checks++;
    if (accepts != 3) begin
      n_fail++;
      $display("FAIL b2b_rate: got %0d accepts in 6 cycles want 3", accepts);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_done: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_pair();
    test_backpressure();
    test_none_and_err();
    test_duplicate();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
